// File: rtl/scr1_tapc_os_pkg.sv
// Shared TAP state type, instruction codes and chain ids for the oversampled TAP controller.
package scr1_tapc_os_pkg;

  typedef enum logic [3:0] {
    SCR1_TAPC_STATE_RESET,
    SCR1_TAPC_STATE_IDLE,
    SCR1_TAPC_STATE_DR_SEL_SCAN,
    SCR1_TAPC_STATE_DR_CAPTURE,
    SCR1_TAPC_STATE_DR_SHIFT,
    SCR1_TAPC_STATE_DR_EXIT1,
    SCR1_TAPC_STATE_DR_PAUSE,
    SCR1_TAPC_STATE_DR_EXIT2,
    SCR1_TAPC_STATE_DR_UPDATE,
    SCR1_TAPC_STATE_IR_SEL_SCAN,
    SCR1_TAPC_STATE_IR_CAPTURE,
    SCR1_TAPC_STATE_IR_SHIFT,
    SCR1_TAPC_STATE_IR_EXIT1,
    SCR1_TAPC_STATE_IR_PAUSE,
    SCR1_TAPC_STATE_IR_EXIT2,
    SCR1_TAPC_STATE_IR_UPDATE
  } type_scr1_tapc_state_e;

  localparam logic [4:0] SCR1_TAPC_IR_IDCODE  = 5'h01;
  localparam logic [4:0] SCR1_TAPC_IR_DTM_SCU = 5'h09;
  localparam logic [4:0] SCR1_TAPC_IR_DMI     = 5'h11;
  localparam logic [4:0] SCR1_TAPC_IR_BYPASS  = 5'h1F;
  localparam logic [4:0] SCR1_TAPC_IR_CAPTURE = 5'b00001;

  localparam logic SCR1_TAPC_CH_ID_SCU = 1'b0;
  localparam logic SCR1_TAPC_CH_ID_DMI = 1'b1;

  function automatic type_scr1_tapc_state_e scr1_tapc_next_state(
    input type_scr1_tapc_state_e s,
    input logic                  tms
  );
    type_scr1_tapc_state_e n;
    case (s)
      SCR1_TAPC_STATE_RESET:       n = tms ? SCR1_TAPC_STATE_RESET       : SCR1_TAPC_STATE_IDLE;
      SCR1_TAPC_STATE_IDLE:        n = tms ? SCR1_TAPC_STATE_DR_SEL_SCAN : SCR1_TAPC_STATE_IDLE;
      SCR1_TAPC_STATE_DR_SEL_SCAN: n = tms ? SCR1_TAPC_STATE_IR_SEL_SCAN : SCR1_TAPC_STATE_DR_CAPTURE;
      SCR1_TAPC_STATE_DR_CAPTURE:  n = tms ? SCR1_TAPC_STATE_DR_EXIT1    : SCR1_TAPC_STATE_DR_SHIFT;
      SCR1_TAPC_STATE_DR_SHIFT:    n = tms ? SCR1_TAPC_STATE_DR_EXIT1    : SCR1_TAPC_STATE_DR_SHIFT;
      SCR1_TAPC_STATE_DR_EXIT1:    n = tms ? SCR1_TAPC_STATE_DR_UPDATE   : SCR1_TAPC_STATE_DR_PAUSE;
      SCR1_TAPC_STATE_DR_PAUSE:    n = tms ? SCR1_TAPC_STATE_DR_EXIT2    : SCR1_TAPC_STATE_DR_PAUSE;
      SCR1_TAPC_STATE_DR_EXIT2:    n = tms ? SCR1_TAPC_STATE_DR_UPDATE   : SCR1_TAPC_STATE_DR_SHIFT;
      SCR1_TAPC_STATE_DR_UPDATE:   n = tms ? SCR1_TAPC_STATE_DR_SEL_SCAN : SCR1_TAPC_STATE_IDLE;
      SCR1_TAPC_STATE_IR_SEL_SCAN: n = tms ? SCR1_TAPC_STATE_RESET       : SCR1_TAPC_STATE_IR_CAPTURE;
      SCR1_TAPC_STATE_IR_CAPTURE:  n = tms ? SCR1_TAPC_STATE_IR_EXIT1    : SCR1_TAPC_STATE_IR_SHIFT;
      SCR1_TAPC_STATE_IR_SHIFT:    n = tms ? SCR1_TAPC_STATE_IR_EXIT1    : SCR1_TAPC_STATE_IR_SHIFT;
      SCR1_TAPC_STATE_IR_EXIT1:    n = tms ? SCR1_TAPC_STATE_IR_UPDATE   : SCR1_TAPC_STATE_IR_PAUSE;
      SCR1_TAPC_STATE_IR_PAUSE:    n = tms ? SCR1_TAPC_STATE_IR_EXIT2    : SCR1_TAPC_STATE_IR_PAUSE;
      SCR1_TAPC_STATE_IR_EXIT2:    n = tms ? SCR1_TAPC_STATE_IR_UPDATE   : SCR1_TAPC_STATE_IR_SHIFT;
      SCR1_TAPC_STATE_IR_UPDATE:   n = tms ? SCR1_TAPC_STATE_DR_SEL_SCAN : SCR1_TAPC_STATE_IDLE;
      default:                     n = SCR1_TAPC_STATE_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/scr1_tapc_os_edge_det.sv
// JTAG pin synchronizers and TCK edge detection; SCR1_TAPC_OS_GLITCH_FILTER_EN adds a 2-sample TCK filter.
module scr1_tapc_os_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  input  logic trst_n,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s,
  output logic trst_n_s
);

  logic [SYNC_STAGES-1:0] tck_sync;
  logic [SYNC_STAGES-1:0] tms_sync;
  logic [SYNC_STAGES-1:0] tdi_sync;
  logic [SYNC_STAGES-1:0] trst_sync;
  logic                   tck_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync  <= '0;
      tms_sync  <= '0;
      tdi_sync  <= '0;
      trst_sync <= '0;
    end else begin
      tck_sync  <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync  <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      trst_sync <= {trst_sync[SYNC_STAGES-2:0], trst_n};
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign trst_n_s = trst_sync[SYNC_STAGES-1];

`ifdef SCR1_TAPC_OS_GLITCH_FILTER_EN
  // tck_f only follows tck_s once two consecutive samples agree; TMS/TDI are
  // delayed one stage so they line up with the first of those samples.
  logic tck_q1;
  logic tck_f;
  logic tms_d;
  logic tdi_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_q1 <= 1'b0;
      tck_f  <= 1'b0;
      tms_d  <= 1'b0;
      tdi_d  <= 1'b0;
    end else begin
      tck_q1 <= tck_s;
      if (tck_s == tck_q1) tck_f <= tck_s;
      tms_d  <= tms_sync[SYNC_STAGES-1];
      tdi_d  <= tdi_sync[SYNC_STAGES-1];
    end
  end

  assign tck_rise = tck_s & tck_q1 & ~tck_f;
  assign tck_fall = ~tck_s & ~tck_q1 & tck_f;
  assign tms_s    = tms_d;
  assign tdi_s    = tdi_d;
`else
  logic tck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tck_q <= 1'b0;
    else        tck_q <= tck_s;
  end

  assign tck_rise = tck_s & ~tck_q;
  assign tck_fall = ~tck_s & tck_q;
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/scr1_tapc_os.sv
// Oversampled IEEE 1149.1 TAP controller in the clk domain feeding SCU/DMI chains.
// Optional macro: SCR1_TAPC_OS_GLITCH_FILTER_EN (2-sample TCK filter in the edge detector).
module scr1_tapc_os
  import scr1_tapc_os_pkg::*;
#(
  parameter int unsigned SCR1_TAPC_IR_WIDTH    = 5,
  parameter logic [31:0] SCR1_TAPC_IDCODE      = 32'h1000_0DB3,
  parameter int unsigned SCR1_TAPC_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic pwrup_rst_n_sync,
  input  logic jtag_trst_n,
  input  logic jtag_tck,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  output logic jtag_tdo_en,
  output logic tapc_ch_sel,
  output logic tapc_ch_id,
  output logic tapc_ch_capture,
  output logic tapc_ch_shift,
  output logic tapc_ch_update,
  output logic tapc_ch_tdi,
  input  logic tapc_ch_tdo
);

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_n_s;

  type_scr1_tapc_state_e          state;
  logic [SCR1_TAPC_IR_WIDTH-1:0]  ir;
  logic [SCR1_TAPC_IR_WIDTH-1:0]  ir_shift;
  logic [31:0]                    dr_idcode;
  logic                           dr_bypass;
  logic                           dr_tdo;

  scr1_tapc_os_edge_det #(
    .SYNC_STAGES (SCR1_TAPC_SYNC_STAGES)
  ) i_edge_det (
    .clk      (clk),
    .rst_n    (pwrup_rst_n_sync),
    .tck      (jtag_tck),
    .tms      (jtag_tms),
    .tdi      (jtag_tdi),
    .trst_n   (jtag_trst_n),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s),
    .trst_n_s (trst_n_s)
  );

  always_comb begin
    tapc_ch_sel = 1'b0;
    tapc_ch_id  = SCR1_TAPC_CH_ID_SCU;
    case (ir)
      SCR1_TAPC_IR_DTM_SCU: tapc_ch_sel = 1'b1;
      SCR1_TAPC_IR_DMI: begin
        tapc_ch_sel = 1'b1;
        tapc_ch_id  = SCR1_TAPC_CH_ID_DMI;
      end
      default: ;
    endcase
  end

  // Unknown instructions fall through to the bypass bit.
  assign dr_tdo = tapc_ch_sel                 ? tapc_ch_tdo  :
                  (ir == SCR1_TAPC_IR_IDCODE) ? dr_idcode[0] : dr_bypass;

  always_ff @(posedge clk or negedge pwrup_rst_n_sync) begin
    if (!pwrup_rst_n_sync) begin
      state       <= SCR1_TAPC_STATE_RESET;
      ir          <= SCR1_TAPC_IR_IDCODE;
      ir_shift    <= '0;
      dr_idcode   <= '0;
      dr_bypass   <= 1'b0;
      jtag_tdo    <= 1'b0;
      jtag_tdo_en <= 1'b0;
    end else if (!trst_n_s) begin
      state       <= SCR1_TAPC_STATE_RESET;
      ir          <= SCR1_TAPC_IR_IDCODE;
      jtag_tdo_en <= 1'b0;
    end else begin
      if (tck_rise) begin
        state <= scr1_tapc_next_state(state, tms_s);
        case (state)
          SCR1_TAPC_STATE_IR_CAPTURE: ir_shift <= SCR1_TAPC_IR_CAPTURE;
          SCR1_TAPC_STATE_IR_SHIFT:   ir_shift <= {tdi_s, ir_shift[SCR1_TAPC_IR_WIDTH-1:1]};
          SCR1_TAPC_STATE_DR_CAPTURE: begin
            dr_idcode <= SCR1_TAPC_IDCODE;
            dr_bypass <= 1'b0;
          end
          SCR1_TAPC_STATE_DR_SHIFT: begin
            dr_idcode <= {tdi_s, dr_idcode[31:1]};
            dr_bypass <= tdi_s;
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        jtag_tdo_en <= (state == SCR1_TAPC_STATE_IR_SHIFT) || (state == SCR1_TAPC_STATE_DR_SHIFT);
        if (state == SCR1_TAPC_STATE_IR_SHIFT)      jtag_tdo <= ir_shift[0];
        else if (state == SCR1_TAPC_STATE_DR_SHIFT) jtag_tdo <= dr_tdo;
        if (state == SCR1_TAPC_STATE_IR_UPDATE)     ir <= ir_shift;
      end
      if (state == SCR1_TAPC_STATE_RESET) ir <= SCR1_TAPC_IR_IDCODE;
    end
  end

  assign tapc_ch_capture = tck_rise & trst_n_s & (state == SCR1_TAPC_STATE_DR_CAPTURE) & tapc_ch_sel;
  assign tapc_ch_shift   = tck_rise & trst_n_s & (state == SCR1_TAPC_STATE_DR_SHIFT)   & tapc_ch_sel;
  assign tapc_ch_update  = tck_fall & trst_n_s & (state == SCR1_TAPC_STATE_DR_UPDATE)  & tapc_ch_sel;
  assign tapc_ch_tdi     = tdi_s;

endmodule

// File: tb/tb_scr1_tapc_os.sv
// Directed bench for scr1_tapc_os: IDCODE, IR capture/load, chain strobes, bypass, TMS/TRST/power-up reset.
module tb_scr1_tapc_os;
  import scr1_tapc_os_pkg::*;

  logic clk = 1'b0;
  logic pwrup_rst_n_sync = 1'b0;
  logic jtag_trst_n = 1'b1;
  logic jtag_tck = 1'b0;
  logic jtag_tms = 1'b0;
  logic jtag_tdi = 1'b0;
  logic tapc_ch_tdo = 1'b0;
  logic jtag_tdo, jtag_tdo_en, tapc_ch_sel, tapc_ch_id;
  logic tapc_ch_capture, tapc_ch_shift, tapc_ch_update, tapc_ch_tdi;

  int checks = 0;
  int failures = 0;
  int cap_cnt = 0;
  int sh_cnt = 0;
  int upd_cnt = 0;
  logic [7:0] tdi_log = '0;

  scr1_tapc_os #(
    .SCR1_TAPC_IR_WIDTH    (5),
    .SCR1_TAPC_IDCODE      (32'h1000_0DB3),
    .SCR1_TAPC_SYNC_STAGES (2)
  ) dut (
    .clk              (clk),
    .pwrup_rst_n_sync (pwrup_rst_n_sync),
    .jtag_trst_n      (jtag_trst_n),
    .jtag_tck         (jtag_tck),
    .jtag_tms         (jtag_tms),
    .jtag_tdi         (jtag_tdi),
    .jtag_tdo         (jtag_tdo),
    .jtag_tdo_en      (jtag_tdo_en),
    .tapc_ch_sel      (tapc_ch_sel),
    .tapc_ch_id       (tapc_ch_id),
    .tapc_ch_capture  (tapc_ch_capture),
    .tapc_ch_shift    (tapc_ch_shift),
    .tapc_ch_update   (tapc_ch_update),
    .tapc_ch_tdi      (tapc_ch_tdi),
    .tapc_ch_tdo      (tapc_ch_tdo)
  );

  always #5 clk = ~clk;

  // Counts strobe-high clk cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (tapc_ch_capture) cap_cnt <= cap_cnt + 1;
    if (tapc_ch_update)  upd_cnt <= upd_cnt + 1;
    if (tapc_ch_shift) begin
      sh_cnt  <= sh_cnt + 1;
      tdi_log <= {tdi_log[6:0], tapc_ch_tdi};
    end
  end

  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic en_v);
    jtag_tms = tms_v;
    jtag_tdi = tdi_v;
    repeat (8) @(negedge clk);
    tdo_v = jtag_tdo;
    en_v  = jtag_tdo_en;
    jtag_tck = 1'b1;
    repeat (8) @(negedge clk);
    jtag_tck = 1'b0;
  endtask

  task automatic goto_idle();
    logic t, e;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
  endtask

  task automatic load_ir(input logic [4:0] code, output logic [4:0] cap);
    logic t, e;
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, code[i], t, e);
      cap[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                         output logic en_all, output logic en_after);
    logic t, e;
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    dout = '0;
    en_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], t, e);
      dout[i] = t;
      en_all &= e;
    end
    tck_cycle(1'b1, 1'b0, t, e);
    en_after = e;
    tck_cycle(1'b0, 1'b0, t, e);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (jtag_tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo got=%b exp=0", jtag_tdo); end
    checks++; if (jtag_tdo_en !== 1'b0) begin failures++; $display("FAIL reset_tdo_en got=%b exp=0", jtag_tdo_en); end
    checks++; if ({tapc_ch_sel, tapc_ch_id} !== 2'b00) begin failures++; $display("FAIL reset_ch got=%b exp=00", {tapc_ch_sel, tapc_ch_id}); end
    checks++; if ({tapc_ch_capture, tapc_ch_shift, tapc_ch_update} !== 3'b000) begin failures++;
      $display("FAIL reset_strobes got=%b exp=000", {tapc_ch_capture, tapc_ch_shift, tapc_ch_update}); end
    pwrup_rst_n_sync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_idcode(input string tag);
    logic [31:0] d;
    logic ea, ef;
    goto_idle();
    scan_dr(32, 32'h0, d, ea, ef);
    checks++; if (d !== 32'h1000_0DB3) begin failures++; $display("FAIL %s_idcode got=%h exp=10000db3", tag, d); end
    checks++; if (ea !== 1'b1) begin failures++; $display("FAIL %s_tdo_en_shift got=%b exp=1", tag, ea); end
    checks++; if (ef !== 1'b0) begin failures++; $display("FAIL %s_tdo_en_exit got=%b exp=0", tag, ef); end
  endtask

  task automatic test_ir_capture();
    logic [4:0] c;
    load_ir(5'h11, c);
    checks++; if (c !== 5'b00001) begin failures++; $display("FAIL ir_capture got=%b exp=00001", c); end
    checks++; if ({tapc_ch_sel, tapc_ch_id} !== 2'b11) begin failures++; $display("FAIL dmi_sel got=%b exp=11", {tapc_ch_sel, tapc_ch_id}); end
  endtask

  task automatic test_scu_chain();
    logic [4:0] c;
    logic [31:0] d;
    logic ea, ef;
    int c0, s0, u0;
    load_ir(5'h09, c);
    checks++; if ({tapc_ch_sel, tapc_ch_id} !== 2'b10) begin failures++; $display("FAIL scu_sel got=%b exp=10", {tapc_ch_sel, tapc_ch_id}); end
    c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
    tapc_ch_tdo = 1'b1;
    scan_dr(8, 32'h0000_00A5, d, ea, ef);
    tapc_ch_tdo = 1'b0;
    checks++; if (cap_cnt - c0 !== 1) begin failures++; $display("FAIL scu_capture_cycles got=%0d exp=1", cap_cnt - c0); end
    checks++; if (sh_cnt - s0 !== 8) begin failures++; $display("FAIL scu_shift_cycles got=%0d exp=8", sh_cnt - s0); end
    checks++; if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL scu_update_cycles got=%0d exp=1", upd_cnt - u0); end
    // tdi order 1,0,1,0,0,1,0,1 with first bit at MSB
    checks++; if (tdi_log !== 8'b1010_0101) begin failures++; $display("FAIL scu_ch_tdi got=%b exp=10100101", tdi_log); end
    checks++; if (d[7:0] !== 8'hFF) begin failures++; $display("FAIL scu_tdo_from_chain got=%h exp=ff", d[7:0]); end
  endtask

  task automatic test_bypass(input logic [4:0] code);
    logic [4:0] c;
    logic [31:0] d;
    logic ea, ef;
    int s0;
    load_ir(code, c);
    s0 = sh_cnt;
    // tdi 1,1,0,1 in time order; tdo expected 0,1,1,0
    scan_dr(4, 32'h0000_000B, d, ea, ef);
    checks++; if (d[3:0] !== 4'b0110) begin failures++; $display("FAIL bypass_%h got=%b exp=0110", code, d[3:0]); end
    checks++; if (sh_cnt - s0 !== 0) begin failures++; $display("FAIL bypass_%h_strobe got=%0d exp=0", code, sh_cnt - s0); end
  endtask

  task automatic test_tms_reset();
    logic [4:0] c;
    logic t, e;
    int u0;
    load_ir(5'h1F, c);
    u0 = upd_cnt;
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b1, t, e);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, e);
    repeat (8) @(negedge clk);
    checks++; if (dut.state !== SCR1_TAPC_STATE_RESET) begin failures++; $display("FAIL tms5_state got=%0d exp=0", dut.state); end
    checks++; if (dut.ir !== 5'h01) begin failures++; $display("FAIL tms5_ir got=%h exp=01", dut.ir); end
    checks++; if (upd_cnt - u0 !== 0) begin failures++; $display("FAIL tms5_update got=%0d exp=0", upd_cnt - u0); end
  endtask

  task automatic test_trst();
    logic [4:0] c;
    logic t, e;
    int s0, u0;
    load_ir(5'h11, c);
    s0 = sh_cnt; u0 = upd_cnt;
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    for (int i = 0; i < 4; i++) tck_cycle(1'b0, 1'b1, t, e);
    jtag_trst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (dut.state !== SCR1_TAPC_STATE_RESET) begin failures++; $display("FAIL trst_state got=%0d exp=0", dut.state); end
    checks++; if ({tapc_ch_sel, jtag_tdo_en} !== 2'b00) begin failures++; $display("FAIL trst_sel_en got=%b exp=00", {tapc_ch_sel, jtag_tdo_en}); end
    jtag_tck = 1'b1;
    repeat (8) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (8) @(negedge clk);
    jtag_trst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (sh_cnt - s0 !== 3) begin failures++; $display("FAIL trst_shift_cycles got=%0d exp=3", sh_cnt - s0); end
    checks++; if (upd_cnt - u0 !== 0) begin failures++; $display("FAIL trst_update got=%0d exp=0", upd_cnt - u0); end
  endtask

  task automatic test_pwrup_mid_scan();
    logic [4:0] c;
    logic t, e;
    goto_idle();
    load_ir(5'h11, c);
    tapc_ch_tdo = 1'b1;
    tck_cycle(1'b1, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    tck_cycle(1'b0, 1'b0, t, e);
    repeat (8) @(negedge clk);
    checks++; if ({jtag_tdo, jtag_tdo_en} !== 2'b11) begin failures++; $display("FAIL pwrup_pre got=%b exp=11", {jtag_tdo, jtag_tdo_en}); end
    pwrup_rst_n_sync = 1'b0;
    #1;
    checks++; if ({jtag_tdo, jtag_tdo_en} !== 2'b00) begin failures++; $display("FAIL pwrup_tdo got=%b exp=00", {jtag_tdo, jtag_tdo_en}); end
    checks++; if ({tapc_ch_sel, tapc_ch_id} !== 2'b00) begin failures++; $display("FAIL pwrup_ch got=%b exp=00", {tapc_ch_sel, tapc_ch_id}); end
    tapc_ch_tdo = 1'b0;
    repeat (3) @(negedge clk);
    pwrup_rst_n_sync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idcode("first");
    test_ir_capture();
    test_scu_chain();
    test_bypass(5'h1F);
    test_bypass(5'h07);
    test_tms_reset();
    test_idcode("after_tms");
    test_trst();
    test_pwrup_mid_scan();
    test_idcode("after_pwrup");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
